hamming_rx_ctrl: RTL and testbench
==================================

Name: hamming_rx_ctrl

Overview:
Receive-side controller for the Hamming(7,4) link. It deserialises the incoming bit stream into 7-bit codewords and computes a syndrome on each one. It corrects single-bit errors and pairs the decoded nibbles into bytes, which leave on a valid/ready handshake. It also keeps a saturating count of corrected errors and flags output overflow. It sits between the line-side bit recovery and the byte-wide consumer.

Parameters:
CNT_W, 8, width of the corrected-error counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
bit_in  input  1  serial line bit, sampled when bit_valid=1
bit_valid  input  1  bit_in qualifier
frame_start  input  1  synchronous resync pulse: restart codeword and nibble alignment
byte_out  output  8  decoded byte {first nibble, second nibble}
byte_valid  output  1  byte_out holds an unconsumed byte
byte_ready  input  1  consumer accepts byte_out when byte_valid & byte_ready
err_count  output  CNT_W  corrected-codeword count, saturating
err_flag  output  1  one-cycle pulse when a nonzero syndrome is decoded
clr_count  input  1  synchronous clear of err_count
overflow  output  1  sticky: a completed byte was dropped; cleared only by rst
busy  output  1  high while a codeword or byte pair is partially received

Behaviour:
- Reset (async, rst=1): all outputs and state are 0. This covers byte_out, byte_valid, err_count, err_flag, overflow, busy, bit counter, nibble phase and the codeword register.
- Codeword layout, first received bit is bit 6: positions 1..7 = bits 6..0 = p1 p2 x3 p4 x2 x1 x0.
  - Data nibble = {bit4, bit2, bit1, bit0}.
- Syndrome:
  - c1 = b6^b4^b2^b0
  - c2 = b5^b4^b1^b0
  - c4 = b3^b2^b1^b0
  - s = {c4,c2,c1} gives the erroneous position (1..7).
  - s=3, 5, 6, 7 inverts b4, b2, b1, b0 respectively.
  - s=1, 2, 4 is a parity-bit error: the nibble is unchanged but the error is still counted.
  - s=0: no error.
- Shift stage:
  - On each bit_valid, shift bit_in in and increment the bit counter (0..6).
  - On the 7th bit, load the codeword register, set the internal cw_valid for one cycle and wrap the counter to 0.
- frame_start:
  - Clears the bit counter and nibble phase.
  - If bit_valid is high in the same cycle, that bit is taken as bit 6 of the new codeword.
  - Partial data is discarded; an already completed byte in byte_out is unaffected.
- Decode stage (cycle after cw_valid):
  - Phase 0: the corrected nibble goes into the high-nibble register and phase becomes 1.
  - Phase 1: the byte {high, corrected nibble} is formed and phase becomes 0.
  - If s≠0: err_flag pulses for 1 cycle and err_count increments, saturating at 2^CNT_W-1.
- Latency: byte_valid rises on the edge following the edge that samples the 7th bit of the second codeword.
- Output handshake:
  - byte_out and byte_valid hold until byte_valid & byte_ready.
  - byte_out is stable while valid.
  - A new byte loads if byte_valid=0, or if byte_valid & byte_ready in the same cycle (back-to-back, no bubble).
  - Otherwise the new byte is dropped, overflow is set, and the old byte is retained.
- clr_count:
  - err_count becomes 0 next cycle.
  - Clear wins over a simultaneous increment; err_flag still pulses.
- busy = (bit counter≠0) | (phase=1) | cw_valid.
- Bit reception is never back-pressured; bit_valid may be high every cycle.
- rst asserted mid-codeword or mid-byte: immediate return to reset state, partial data lost.

Test Plan:
- Clean byte: after reset, serially send codeword 0x5A (nibble A), then 0x25 (nibble 5), bit_valid continuous, byte_ready=1 → byte_out=0xA5 with byte_valid for 1 cycle, 1 cycle after the 14th bit. err_count=0, err_flag never set.
- Single-bit corrections:
  - Send 0x4A (bit4 of 0x5A flipped), then 0x27 (bit1 of 0x25 flipped) → byte_out=0xA5, two err_flag pulses, err_count=2.
  - Send 0x1A (p1 of 0x5A flipped), then 0x25 → byte_out=0xA5, err_count=1.
- Back-pressure/overflow:
  - Hold byte_ready=0 and send 4 codewords (0x5A, 0x25, 0x25, 0x5A) → byte_out stays 0xA5, second byte 0x5A dropped, overflow=1 and stays 1.
  - Then byte_ready=1 → one transfer of 0xA5, byte_valid falls.
- Resync: send 3 bits, then frame_start with bit_valid=1 and bit=0, continuing with 0x5A's remaining six bits and then 0x25 → byte_out=0xA5, the first 3 bits are discarded.
- Counter: force 255 errored codewords with CNT_W=8 → err_count=255. One more error → stays 255. clr_count together with an error → 0.
- Async reset: assert rst after 10 bits → all outputs 0 immediately with no clock edge. After release, a clean 0x5A/0x25 sequence → 0xA5.

Source files
------------

// File: rtl/hamming_rx_ctrl.sv
// ---------------------------------------------------------------------------
// hamming_rx_ctrl
//
// Receive-side controller for a Hamming(7,4) serial link. Incoming bits are
// deserialised into 7-bit codewords (first bit received = bit 6). A syndrome
// is computed on each codeword and single-bit errors are corrected. Decoded
// nibbles are paired into bytes {first, second}, which are offered on a
// valid/ready handshake. Also keeps a saturating count of corrected
// codewords and a sticky overflow flag for bytes dropped under back-pressure.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   bit_in       serial line bit, sampled when bit_valid=1
//   bit_valid    bit_in qualifier
//   frame_start  resync pulse: restart codeword and nibble alignment
//   byte_out     decoded byte {first nibble, second nibble}
//   byte_valid   byte_out holds an unconsumed byte
//   byte_ready   consumer accepts byte_out when byte_valid & byte_ready
//   err_count    saturating count of codewords with a nonzero syndrome
//   err_flag     one-cycle pulse per codeword with a nonzero syndrome
//   clr_count    synchronous clear of err_count (wins over an increment)
//   overflow     sticky: a completed byte was dropped
//   busy         a codeword or byte pair is partially received
// ---------------------------------------------------------------------------
module hamming_rx_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    input  logic             clr_count,
    output logic             overflow,
    output logic             busy
);

    // Nibble phase: which half of the output byte the next codeword fills.
    localparam logic [0:0] PH_HIGH = 1'b0;
    localparam logic [0:0] PH_LOW  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [5:0] shift_reg;     // first six bits of the codeword in flight
    logic [2:0] bit_cnt;       // bits already received of current codeword
    logic [2:0] bit_cnt_eff;   // counter as seen this cycle (after resync)
    logic [6:0] cw_reg;        // completed codeword
    logic       cw_valid;      // cw_reg was loaded on the previous edge
    logic [0:0] phase;
    logic [3:0] hi_nib;

    logic [2:0] syndrome;
    logic [6:0] corrected;
    logic [3:0] nibble;
    logic       cw_err;

    // A resync pulse makes a bit arriving in the same cycle bit 6 of a new
    // codeword, so the counter is overridden before it is used.
    assign bit_cnt_eff = frame_start ? 3'd0 : bit_cnt;

    // Syndrome bits {c4, c2, c1} name the erroneous position 1..7.
    assign syndrome[0] = cw_reg[6] ^ cw_reg[4] ^ cw_reg[2] ^ cw_reg[0];
    assign syndrome[1] = cw_reg[5] ^ cw_reg[4] ^ cw_reg[1] ^ cw_reg[0];
    assign syndrome[2] = cw_reg[3] ^ cw_reg[2] ^ cw_reg[1] ^ cw_reg[0];
    assign cw_err      = cw_valid && (syndrome != 3'd0);

    // NOTE: every combinational output gets a default before the case so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        corrected = cw_reg;
        case (syndrome)
            3'd3:    corrected[4] = ~cw_reg[4];
            3'd5:    corrected[2] = ~cw_reg[2];
            3'd6:    corrected[1] = ~cw_reg[1];
            3'd7:    corrected[0] = ~cw_reg[0];
            default: ;  // 0: clean; 1,2,4: parity bit hit, data intact
        endcase
        nibble = {corrected[4], corrected[2], corrected[1], corrected[0]};
    end

    // Shift stage: deserialise bits into codewords.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            cw_reg    <= '0;
            cw_valid  <= 1'b0;
        end else begin
            cw_valid <= 1'b0;
            if (bit_valid) begin
                if (bit_cnt_eff == 3'd6) begin
                    cw_reg   <= {shift_reg, bit_in};
                    cw_valid <= 1'b1;
                    bit_cnt  <= 3'd0;
                end else begin
                    shift_reg <= {shift_reg[4:0], bit_in};
                    bit_cnt   <= bit_cnt_eff + 3'd1;
                end
            end else if (frame_start) begin
                bit_cnt <= 3'd0;
            end
        end
    end

    // Decode stage: nibble pairing, output handshake and error accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= PH_HIGH;
            hi_nib     <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            overflow   <= 1'b0;
            err_flag   <= 1'b0;
            err_count  <= '0;
        end else begin
            err_flag <= cw_err;

            if (clr_count) begin
                err_count <= '0;
            end else if (cw_err && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_ONE;
            end

            if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end

            // A resync discards the codeword still waiting to be decoded;
            // a byte already sitting in byte_out is left alone.
            if (frame_start) begin
                phase <= PH_HIGH;
            end else if (cw_valid) begin
                if (phase == PH_HIGH) begin
                    hi_nib <= nibble;
                    phase  <= PH_LOW;
                end else begin
                    phase <= PH_HIGH;
                    // Load when the slot is empty or being drained this
                    // cycle; otherwise keep the old byte and drop the new.
                    if (!byte_valid || byte_ready) begin
                        byte_out   <= {hi_nib, nibble};
                        byte_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy = (bit_cnt != 3'd0) || (phase == PH_LOW) || cw_valid;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hamming_rx_ctrl
//
// Directed bench for hamming_rx_ctrl. Stimulus tasks push the expected byte
// into a queue whenever a nibble pair is completed; a separate monitor pops
// and compares on every accepted byte_valid & byte_ready beat, counts
// err_flag pulses and checks byte_out stability while stalled.
// ---------------------------------------------------------------------------
module tb_hamming_rx_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_ready = 1'b1;
    logic [CNT_W-1:0] err_count;
    logic             err_flag;
    logic             clr_count = 1'b0;
    logic             overflow;
    logic             busy;

    hamming_rx_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .frame_start(frame_start),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .err_count  (err_count),
        .err_flag   (err_flag),
        .clr_count  (clr_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp    = 0;
    int         n_fail   = 0;
    int         flag_cnt = 0;
    logic [7:0] exp_q[$];
    logic       tb_phase = 1'b0;
    logic [3:0] tb_hi    = 4'h0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic       prev_hold;
        logic [7:0] prev_byte;
        logic [7:0] exp;
        prev_hold = 1'b0;
        prev_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (err_flag) flag_cnt++;
                if (prev_hold && byte_valid)
                    check("byte_stable", {24'd0, byte_out}, {24'd0, prev_byte});
                if (byte_valid && byte_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", byte_out);
                    end else begin
                        exp = exp_q.pop_front();
                        check("byte_out", {24'd0, byte_out}, {24'd0, exp});
                    end
                end
                prev_hold = byte_valid && !byte_ready;
                prev_byte = byte_out;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    // Expected-value model: pairs nibbles into bytes.
    task automatic model_nib(input logic [3:0] nib, input bit drop);
        if (!tb_phase) begin
            tb_hi    = nib;
            tb_phase = 1'b1;
        end else begin
            if (!drop) exp_q.push_back({tb_hi, nib});
            tb_phase = 1'b0;
        end
    endtask

    task automatic send_cw(input logic [6:0] cw, input logic [3:0] nib,
                           input bit drop);
        for (int i = 6; i >= 0; i--) send_bit(cw[i]);
        model_nib(nib, drop);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        clr_count   = 1'b0;
        byte_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        tb_phase = 1'b0;
        flag_cnt = 0;
        tick();
    endtask

    initial begin
        logic [6:0] cw5a;
        cw5a = 7'h5A;

        // Reset state.
        do_reset();
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);

        // Clean byte with latency check.
        send_cw(7'h5A, 4'hA, 0);
        check("busy_mid_pair", busy, 1);
        send_cw(7'h25, 4'h5, 0);
        check("lat_pre_valid", byte_valid, 0);
        tick();
        check("lat_valid", byte_valid, 1);
        check("lat_byte", byte_out, 8'hA5);
        tick();
        check("lat_post_valid", byte_valid, 0);
        check("clean_err_count", err_count, 0);
        check("clean_flags", flag_cnt, 0);
        drain("clean_drain");

        // Data-bit corrections (s=3 and s=6).
        do_reset();
        send_cw(7'h4A, 4'hA, 0);
        send_cw(7'h27, 4'h5, 0);
        idle(3);
        check("corr_err_count", err_count, 2);
        check("corr_flags", flag_cnt, 2);
        drain("corr_drain");

        // Parity-bit error (s=1): counted, data untouched.
        do_reset();
        send_cw(7'h1A, 4'hA, 0);
        send_cw(7'h25, 4'h5, 0);
        idle(3);
        check("par_err_count", err_count, 1);
        check("par_flags", flag_cnt, 1);
        drain("par_drain");

        // Back-pressure: second byte dropped, overflow sticky.
        do_reset();
        byte_ready = 1'b0;
        send_cw(7'h5A, 4'hA, 0);
        send_cw(7'h25, 4'h5, 0);
        send_cw(7'h25, 4'h5, 0);
        send_cw(7'h5A, 4'hA, 1);
        idle(3);
        check("ovf_valid_held", byte_valid, 1);
        check("ovf_byte_held", byte_out, 8'hA5);
        check("ovf_flag", overflow, 1);
        byte_ready = 1'b1;
        tick();
        check("ovf_valid_fall", byte_valid, 0);
        check("ovf_sticky", overflow, 1);
        drain("ovf_drain");

        // Async reset mid-byte, with no clock edge.
        send_cw(7'h4A, 4'hA, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_rst_err_count", err_count, 1);
        check("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_byte_out", byte_out, 0);
        check("arst_byte_valid", byte_valid, 0);
        check("arst_err_count", err_count, 0);
        check("arst_err_flag", err_flag, 0);
        check("arst_overflow", overflow, 0);
        check("arst_busy", busy, 0);
        exp_q.delete();
        do_reset();
        send_cw(7'h5A, 4'hA, 0);
        send_cw(7'h25, 4'h5, 0);
        idle(3);
        drain("arst_clean_drain");
        check("arst_clean_err", err_count, 0);

        // Resync: frame_start discards three bits and an open nibble pair.
        do_reset();
        send_cw(7'h25, 4'h5, 0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("resync_busy", busy, 1);
        frame_start = 1'b1;
        tb_phase    = 1'b0;
        send_bit(1'b0);  // codeword becomes 0x1A: p1 error, nibble A
        frame_start = 1'b0;
        for (int i = 5; i >= 0; i--) send_bit(cw5a[i]);
        model_nib(4'hA, 0);
        send_cw(7'h25, 4'h5, 0);
        idle(3);
        drain("resync_drain");
        check("resync_err_count", err_count, 1);

        // Saturating counter and clear priority.
        do_reset();
        repeat (255) send_cw(7'h1A, 4'hA, 0);
        idle(3);
        check("cnt_255", err_count, 255);
        send_cw(7'h1A, 4'hA, 0);
        idle(3);
        check("cnt_sat", err_count, 255);
        check("cnt_flags", flag_cnt, 256);
        send_cw(7'h1A, 4'hA, 0);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("cnt_clr_wins", err_count, 0);
        idle(3);
        check("cnt_clr_flag", flag_cnt, 257);
        check("cnt_clr_hold", err_count, 0);
        drain("cnt_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
